plic_claim_agent: RTL and testbench
===================================

PLIC_CLAIM_AGENT -- requirements
Module: plic_claim_agent

Interface
REQ-001 SHALL have parameter N_SOURCE, default 30: number of PLIC interrupt sources.
REQ-002 SHALL have parameter SRCW, default $clog2(N_SOURCE+1): interrupt ID width.
REQ-003 SHALL have parameter TARGET, default 0: PLIC target (context) index this agent serves.
REQ-004 SHALL have parameter BASE_ADDR, default 32'h0C00_0000: PLIC base address.
REQ-005 SHALL have parameter HOLDOFF, default 4: idle cycles enforced after each completion write, range 0..15.
REQ-006 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-007 SHALL have port rst_ni, input, 1 bit: reset, asynchronous and active-low.
REQ-008 SHALL have port en_i, input, 1 bit: agent enable.
REQ-009 SHALL have port eip_i, input, 1 bit: external interrupt pending from the PLIC for this target.
REQ-010 SHALL have port req_o, output, reg_intf::reg_intf_req_a32_d32: register bus request (addr, write, wdata, wstrb, valid).
REQ-011 SHALL have port resp_i, input, reg_intf::reg_intf_resp_d32: register bus response (rdata, error, ready).
REQ-012 SHALL have port id_valid_o, output, 1 bit: a claimed ID is offered to the handler.
REQ-013 SHALL have port id_o, output, SRCW bits: the claimed interrupt ID.
REQ-014 SHALL have port id_ready_i, input, 1 bit: the handler accepts the ID.
REQ-015 SHALL have port done_i, input, 1 bit: single-cycle pulse meaning the handler has finished servicing.
REQ-016 SHALL have port busy_o, output, 1 bit: high whenever the state is not IDLE.
REQ-017 SHALL have port spurious_cnt_o, output, 8 bits: saturating count of claims that returned ID 0.
REQ-018 SHALL have port bus_err_o, output, 1 bit: sticky bus error flag.
REQ-019 SHALL have port clr_i, input, 1 bit: clears spurious_cnt_o and bus_err_o.

Function
REQ-020 SHALL compute the claim/complete address CC_ADDR = BASE_ADDR + 32'h20_0004 + TARGET*32'h1000.
REQ-021 SHALL implement exactly these states: IDLE, CLAIM, DISPATCH, SERVICE, COMPLETE, HOLD.
REQ-022 SHALL move IDLE->CLAIM in the cycle after a clock edge that samples en_i=1 and eip_i=1.
REQ-023 SHALL in CLAIM drive req_o.valid=1, write=0, addr=CC_ADDR, wstrb=4'h0, and hold these stable until resp_i.ready=1.
REQ-024 SHALL, on CLAIM with ready=1 and error=0, capture rdata[SRCW-1:0]; if nonzero go to DISPATCH, if zero increment spurious_cnt_o (saturating at 255) and go to IDLE.
REQ-025 SHALL, on any bus transfer with ready=1 and error=1, set bus_err_o and go to IDLE, with no completion write issued.
REQ-026 SHALL in DISPATCH hold id_valid_o=1 and id_o stable; when id_ready_i=1, go to SERVICE.
REQ-027 SHALL in SERVICE wait for done_i=1, then go to COMPLETE; done_i SHALL be ignored in every other state.
REQ-028 SHALL in COMPLETE drive valid=1, write=1, addr=CC_ADDR, wdata={zero-extended ID}, wstrb=4'hF, held until ready=1; then go to HOLD.
REQ-029 SHALL in HOLD count HOLDOFF cycles, then go to IDLE; HOLDOFF=0 SHALL go to IDLE on the next cycle.
REQ-030 SHALL let en_i=0 block only the IDLE->CLAIM transition; a transaction in progress SHALL run to completion.
REQ-031 SHALL, when clr_i=1 coincides with a spurious increment or a new error, give clr_i priority (values cleared).
REQ-032 SHALL drive req_o.valid=0 and id_valid_o=0 in every state other than those stated above.
REQ-033 SHALL have at most one bus transaction outstanding at any time.

Reset
REQ-034 SHALL, with rst_ni=0, asynchronously enter IDLE and force: req_o all zeros, id_valid_o=0, id_o=0, busy_o=0, spurious_cnt_o=0, bus_err_o=0, hold counter=0.
REQ-035 SHALL, on reset asserted mid-transaction, drop req_o.valid immediately and issue no completion write after release.

Verification
REQ-036 SHALL check: TARGET=1, eip_i=1, claim returns 5 -> read at 32'h0C20_1004; id_o=5 offered; after done_i, write wdata=5 to the same address; then HOLDOFF idle cycles.
REQ-037 SHALL check: claim returns 0 -> spurious_cnt_o goes 0->1, no DISPATCH and no write; after 256 such claims -> spurious_cnt_o stays at 255.
REQ-038 SHALL check: claim ready delayed 7 cycles -> req_o stable for all 7 cycles, exactly one transfer.
REQ-039 SHALL check: claim error=1 -> bus_err_o=1, state IDLE; clr_i pulse -> bus_err_o=0.
REQ-040 SHALL check: en_i dropped during SERVICE -> completion still written; no new claim while en_i=0 even if eip_i=1.
REQ-041 SHALL check: rst_ni asserted during COMPLETE wait -> req_o.valid=0 in the same cycle; all outputs at reset values.

Source files
------------

// File: rtl/plic_claim_agent_if.sv
// rtl/plic_claim_agent_if.sv - register bus types and the request/response bundle for plic_claim_agent
//
// reg_intf             : packed request/response structs of the 32-bit register bus.
// plic_claim_agent_if  : carries one request and one response.
//    master modport    : drives req, samples resp (the claim agent side)
//    slave modport     : samples req, drives resp (the PLIC register side)

package reg_intf;

   typedef struct packed {
      logic [31:0] addr;
      logic        write;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic        valid;
   } reg_intf_req_a32_d32;

   typedef struct packed {
      logic [31:0] rdata;
      logic        error;
      logic        ready;
   } reg_intf_resp_d32;

endpackage

interface plic_claim_agent_if;

   reg_intf::reg_intf_req_a32_d32 req;
   reg_intf::reg_intf_resp_d32    resp;

   modport master (output req, input resp);
   modport slave  (input req, output resp);

endinterface

// File: rtl/plic_claim_agent.sv
// rtl/plic_claim_agent.sv - claims, dispatches and completes PLIC interrupts for one target
//
// Ports:
//    clk_i, rst_ni      : clock, asynchronous active-low reset
//    en_i               : allows a new claim to start (never aborts one in flight)
//    eip_i              : external interrupt pending for this target
//    req_o / resp_i     : register bus to the PLIC claim/complete register
//    id_valid_o, id_o,
//    id_ready_i         : claimed ID offered to the handler
//    done_i             : handler finished servicing (pulse, honoured only in SERVICE)
//    busy_o             : agent is not idle
//    spurious_cnt_o     : saturating count of claims that returned ID 0
//    bus_err_o          : sticky bus error flag
//    clr_i              : clears spurious_cnt_o and bus_err_o

module plic_claim_agent #(
   parameter int          N_SOURCE  = 30,
   parameter int          SRCW      = $clog2(N_SOURCE + 1),
   parameter int          TARGET    = 0,
   parameter logic [31:0] BASE_ADDR = 32'h0C00_0000,
   parameter int          HOLDOFF   = 4
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic                          en_i,
   input  logic                          eip_i,
   output reg_intf::reg_intf_req_a32_d32 req_o,
   input  reg_intf::reg_intf_resp_d32    resp_i,
   output logic                          id_valid_o,
   output logic [SRCW-1:0]               id_o,
   input  logic                          id_ready_i,
   input  logic                          done_i,
   output logic                          busy_o,
   output logic [7:0]                    spurious_cnt_o,
   output logic                          bus_err_o,
   input  logic                          clr_i
);

   localparam logic [31:0] CC_ADDR = BASE_ADDR + 32'h0020_0004 + 32'(TARGET) * 32'h0000_1000;
   localparam logic [4:0]  HOLD_N  = 5'(HOLDOFF);

   typedef enum logic [2:0] {
      IDLE, CLAIM, DISPATCH, SERVICE, COMPLETE, HOLD
   } state_e;

   state_e          state_q, state_d;
   logic [SRCW-1:0] id_q, id_d;
   logic [3:0]      hold_cnt_q, hold_cnt_d;
   logic [7:0]      spur_q, spur_d;
   logic            err_q, err_d;

   logic            xfer_ok, xfer_err, hold_done;
   logic            unused_rdata;

   assign unused_rdata = ^resp_i.rdata[31:SRCW];

   // Bus events only count while a request is actually being driven.
   assign xfer_ok   = resp_i.ready & ~resp_i.error;
   assign xfer_err  = resp_i.ready &  resp_i.error;
   // HOLDOFF=0 still spends one cycle in HOLD before returning to IDLE.
   assign hold_done = ({1'b0, hold_cnt_q} + 5'd1) >= HOLD_N;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         id_q       <= '0;
         hold_cnt_q <= '0;
         spur_q     <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         id_q       <= id_d;
         hold_cnt_q <= hold_cnt_d;
         spur_q     <= spur_d;
         err_q      <= err_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      id_d       = id_q;
      hold_cnt_d = hold_cnt_q;
      spur_d     = spur_q;
      err_d      = err_q;
      unique case (state_q)
         IDLE: begin
            if (en_i && eip_i) state_d = CLAIM;
         end
         CLAIM: begin
            if (xfer_err) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end else if (xfer_ok) begin
               id_d = resp_i.rdata[SRCW-1:0];
               if (resp_i.rdata[SRCW-1:0] != '0) begin
                  state_d = DISPATCH;
               end else begin
                  if (spur_q != 8'hFF) spur_d = spur_q + 8'd1;
                  state_d = IDLE;
               end
            end
         end
         DISPATCH: begin
            if (id_ready_i) state_d = SERVICE;
         end
         SERVICE: begin
            if (done_i) state_d = COMPLETE;
         end
         COMPLETE: begin
            if (xfer_err) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end else if (xfer_ok) begin
               hold_cnt_d = '0;
               state_d    = HOLD;
            end
         end
         HOLD: begin
            if (hold_done) begin
               hold_cnt_d = '0;
               state_d    = IDLE;
            end else begin
               hold_cnt_d = hold_cnt_q + 4'd1;
            end
         end
         default: state_d = IDLE;
      endcase
      // Clear wins over a same-cycle increment or new error.
      if (clr_i) begin
         spur_d = '0;
         err_d  = 1'b0;
      end
   end

   always_comb begin
      req_o      = '0;
      id_valid_o = 1'b0;
      unique case (state_q)
         CLAIM: begin
            req_o.valid = 1'b1;
            req_o.addr  = CC_ADDR;
         end
         COMPLETE: begin
            req_o.valid = 1'b1;
            req_o.write = 1'b1;
            req_o.addr  = CC_ADDR;
            req_o.wdata = 32'(id_q);
            req_o.wstrb = 4'hF;
         end
         DISPATCH: id_valid_o = 1'b1;
         default: ;
      endcase
   end

   assign id_o           = id_q;
   assign busy_o         = (state_q != IDLE);
   assign spurious_cnt_o = spur_q;
   assign bus_err_o      = err_q;

endmodule

// File: tb/tb_plic_claim_agent.sv
// tb/tb_plic_claim_agent.sv - self-checking bench for plic_claim_agent

module tb_plic_claim_agent;

   localparam int          SRCW    = 5;
   localparam int          HOLDOFF = 4;
   localparam logic [31:0] CC      = 32'h0C20_1004;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic en = 1'b0, eip = 1'b0, id_ready = 1'b0, done = 1'b0, clr = 1'b0;
   logic id_valid, busy, berr;
   logic [SRCW-1:0] id;
   logic [7:0] spur;

   plic_claim_agent_if bus ();

   plic_claim_agent #(.N_SOURCE(30), .TARGET(1), .BASE_ADDR(32'h0C00_0000), .HOLDOFF(HOLDOFF)) dut (
      .clk_i(clk), .rst_ni(rst_n), .en_i(en), .eip_i(eip),
      .req_o(bus.req), .resp_i(bus.resp),
      .id_valid_o(id_valid), .id_o(id), .id_ready_i(id_ready), .done_i(done),
      .busy_o(busy), .spurious_cnt_o(spur), .bus_err_o(berr), .clr_i(clr)
   );

   always #5 clk = ~clk;

   int checks = 0, failures = 0;
   int xfers = 0, writes = 0;
   logic [31:0] last_wdata, last_waddr;

   always @(posedge clk) begin
      if (rst_n && bus.req.valid && bus.resp.ready) begin
         xfers = xfers + 1;
         if (bus.req.write) begin
            writes     = writes + 1;
            last_wdata = bus.req.wdata;
            last_waddr = bus.req.addr;
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_resp(input logic rdy, input logic [31:0] rd, input logic er);
      bus.resp.ready = rdy;
      bus.resp.rdata = rd;
      bus.resp.error = er;
   endtask

   // Starts a claim from IDLE, holds ready low for 'delay' cycles, then answers.
   task automatic do_claim(input logic [31:0] rdata, input logic err, input int delay);
      en = 1'b1; eip = 1'b1;
      tick();
      chk("claim_valid", bus.req.valid, 1'b1);
      chk("claim_addr", bus.req.addr, CC);
      chk("claim_write", bus.req.write, 1'b0);
      chk("claim_wstrb", bus.req.wstrb, 4'h0);
      for (int i = 0; i < delay; i++) begin
         set_resp(1'b0, 32'hDEAD_BEEF, 1'b0);
         tick();
         chk("claim_hold_valid", bus.req.valid, 1'b1);
         chk("claim_hold_addr", bus.req.addr, CC);
         chk("claim_hold_write", bus.req.write, 1'b0);
      end
      set_resp(1'b1, rdata, err);
      eip = 1'b0;
      tick();
      set_resp(1'b0, 32'h0, 1'b0);
   endtask

   // From DISPATCH: accept the ID, finish service, and watch the completion and holdoff.
   task automatic finish_service(input logic [SRCW-1:0] exp_id);
      int w0, n;
      chk("disp_valid", id_valid, 1'b1);
      chk("disp_id", id, exp_id);
      tick();
      chk("disp_id_stable", id, exp_id);
      id_ready = 1'b1;
      tick();
      id_ready = 1'b0;
      chk("service_no_id_valid", id_valid, 1'b0);
      chk("service_no_req", bus.req.valid, 1'b0);
      done = 1'b1;
      tick();
      done = 1'b0;
      chk("cmpl_valid", bus.req.valid, 1'b1);
      chk("cmpl_write", bus.req.write, 1'b1);
      chk("cmpl_addr", bus.req.addr, CC);
      chk("cmpl_wdata", bus.req.wdata, 32'(exp_id));
      chk("cmpl_wstrb", bus.req.wstrb, 4'hF);
      w0 = writes;
      set_resp(1'b1, 32'h0, 1'b0);
      tick();
      set_resp(1'b0, 32'h0, 1'b0);
      chk("cmpl_one_write", writes, w0 + 1);
      chk("cmpl_wdata_seen", last_wdata, 32'(exp_id));
      chk("cmpl_waddr_seen", last_waddr, CC);
      n = 0;
      while (busy && n < 50) begin
         chk("hold_no_req", bus.req.valid, 1'b0);
         n++;
         tick();
      end
      chk("holdoff_cycles", n, HOLDOFF);
   endtask

   typedef struct {
      logic [31:0]     rdata;
      logic            err;
      int              delay;
      logic            exp_disp;
      logic [SRCW-1:0] exp_id;
      logic [7:0]      exp_spur;
      logic            exp_berr;
   } vec_t;

   vec_t vecs[7];

   initial begin
      int x0, w0;
      vecs[0] = '{32'h0000_0005, 1'b0, 0, 1'b1, 5'd5, 8'd0, 1'b0};
      vecs[1] = '{32'h0000_0000, 1'b0, 0, 1'b0, 5'd0, 8'd1, 1'b0};
      vecs[2] = '{32'hFFFF_FF03, 1'b0, 1, 1'b1, 5'd3, 8'd1, 1'b0};
      vecs[3] = '{32'h0000_0009, 1'b0, 7, 1'b1, 5'd9, 8'd1, 1'b0};
      vecs[4] = '{32'h0000_0000, 1'b0, 2, 1'b0, 5'd0, 8'd2, 1'b0};
      vecs[5] = '{32'h0000_0007, 1'b1, 1, 1'b0, 5'd0, 8'd2, 1'b1};
      vecs[6] = '{32'h0000_0020, 1'b0, 0, 1'b0, 5'd0, 8'd3, 1'b1};

      set_resp(1'b0, 32'h0, 1'b0);
      #1;
      chk("rst_req", bus.req, '0);
      chk("rst_id_valid", id_valid, 1'b0);
      chk("rst_id", id, '0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_spur", spur, 8'd0);
      chk("rst_berr", berr, 1'b0);
      repeat (2) tick();
      rst_n = 1'b1;
      tick();

      // Table of single claims.
      foreach (vecs[k]) begin
         x0 = xfers; w0 = writes;
         do_claim(vecs[k].rdata, vecs[k].err, vecs[k].delay);
         chk("vec_one_xfer", xfers, x0 + 1);
         chk("vec_dispatch", id_valid, vecs[k].exp_disp);
         chk("vec_busy", busy, vecs[k].exp_disp);
         chk("vec_spur", spur, vecs[k].exp_spur);
         chk("vec_berr", berr, vecs[k].exp_berr);
         if (vecs[k].exp_disp) begin
            finish_service(vecs[k].exp_id);
         end else begin
            repeat (3) tick();
            chk("vec_no_write", writes, w0);
            chk("vec_idle", busy, 1'b0);
         end
      end

      clr = 1'b1; tick(); clr = 1'b0;
      chk("clr_berr", berr, 1'b0);
      chk("clr_spur", spur, 8'd0);

      // Saturation of the spurious counter.
      for (int i = 0; i < 256; i++) do_claim(32'h0, 1'b0, 0);
      chk("spur_saturate", spur, 8'd255);

      // en_i dropped during SERVICE, with a stray done_i while in DISPATCH.
      do_claim(32'h0000_000B, 1'b0, 0);
      done = 1'b1; tick(); done = 1'b0;
      chk("done_ignored_dispatch", id_valid, 1'b1);
      id_ready = 1'b1; tick(); id_ready = 1'b0;
      en = 1'b0; eip = 1'b1;
      tick();
      chk("service_wait", busy, 1'b1);
      chk("service_no_req2", bus.req.valid, 1'b0);
      done = 1'b1; tick(); done = 1'b0;
      chk("en0_cmpl_valid", bus.req.valid, 1'b1);
      chk("en0_cmpl_wdata", bus.req.wdata, 32'h0000_000B);
      w0 = writes; x0 = xfers;
      set_resp(1'b1, 32'h0, 1'b0); tick(); set_resp(1'b0, 32'h0, 1'b0);
      chk("en0_cmpl_written", writes, w0 + 1);
      repeat (12) tick();
      chk("en0_no_claim", xfers, x0 + 1);
      chk("en0_idle", busy, 1'b0);
      eip = 1'b0; en = 1'b1;

      // Reset while the completion write waits for ready.
      do_claim(32'h0000_0006, 1'b0, 0);
      id_ready = 1'b1; tick(); id_ready = 1'b0;
      done = 1'b1; tick(); done = 1'b0;
      chk("pre_rst_cmpl_valid", bus.req.valid, 1'b1);
      w0 = writes;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", bus.req.valid, 1'b0);
      chk("mid_rst_req", bus.req, '0);
      chk("mid_rst_id_valid", id_valid, 1'b0);
      chk("mid_rst_id", id, '0);
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_spur", spur, 8'd0);
      chk("mid_rst_berr", berr, 1'b0);
      tick();
      rst_n = 1'b1;
      set_resp(1'b1, 32'h0, 1'b0);
      repeat (8) tick();
      set_resp(1'b0, 32'h0, 1'b0);
      chk("post_rst_no_write", writes, w0);
      chk("post_rst_idle", busy, 1'b0);

      // clr_i wins over a coincident spurious increment and a coincident error.
      en = 1'b1; eip = 1'b1; tick();
      set_resp(1'b1, 32'h0, 1'b0); clr = 1'b1; eip = 1'b0;
      tick();
      set_resp(1'b0, 32'h0, 1'b0); clr = 1'b0;
      chk("clr_prio_spur", spur, 8'd0);
      eip = 1'b1; tick();
      set_resp(1'b1, 32'h0, 1'b1); clr = 1'b1; eip = 1'b0;
      tick();
      set_resp(1'b0, 32'h0, 1'b0); clr = 1'b0;
      chk("clr_prio_err", berr, 1'b0);
      chk("clr_prio_idle", busy, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
